fft_seq_ctrl: RTL and testbench

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

---
 rtl/fft_seq_ctrl_pkg.sv | 8 +
 rtl/fft_seq_ctrl_if.sv | 8 +
 rtl/fft_stage_cnt.sv | 16 +
 rtl/fft_seq_ctrl.sv | 72 +++++++
 tb/tb_fft_seq_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fft_seq_ctrl_pkg.sv
// fft_seq_ctrl_pkg: controller state type and default FFT pipeline geometry
package fft_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_e;
  localparam int N_LOG2_DEF = 3;
  localparam int LAT_DEF    = 7;
  localparam int OFS2_DEF   = 4;
  localparam int OFS3_DEF   = 6;
endpackage

// File: rtl/fft_seq_ctrl_if.sv
// fft_seq_ctrl_if: sample-in / result-out handshake bundle
//   in_valid/in_last -> in_ready : upstream sample stream
//   out_ready -> out_valid/out_last : downstream result stream
interface fft_seq_ctrl_if;
  logic in_valid, in_last, in_ready, out_ready, out_valid, out_last;
  modport master (output in_valid, in_last, out_ready, input in_ready, out_valid, out_last);
  modport slave (input in_valid, in_last, out_ready, output in_ready, out_valid, out_last);
endinterface

// File: rtl/fft_stage_cnt.sv
// fft_stage_cnt: 3-bit wrapping twiddle counter with enable and sync clear
//   clk, reset (async, active-low), en_i advance, clr_i restart, cnt_o count
module fft_stage_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [2:0] cnt_o
);
  logic [2:0] cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 3'd1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: advance/enable sequencer for a 3-stage radix-2 SDF FFT
//   clk, reset (async, active-low)
//   s        : stream handshake (in_valid/in_last/in_ready, out_ready/out_valid/out_last)
//   adv      : pipeline advance strobe
//   stage_en : per-stage twiddle counter advance
//   tw_addr1..3 : per-stage twiddle address; bf_sel : per-stage butterfly mode
//   busy     : controller not idle; frame_err : framing error pulse
module fft_seq_ctrl
  import fft_seq_ctrl_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int LAT    = LAT_DEF,
  parameter int OFS2   = OFS2_DEF,
  parameter int OFS3   = OFS3_DEF
) (
  input  logic          clk,
  input  logic          reset,
  fft_seq_ctrl_if.slave s,
  output logic          adv,
  output logic [2:0]    stage_en,
  output logic [2:0]    tw_addr1,
  output logic [2:0]    tw_addr2,
  output logic [2:0]    tw_addr3,
  output logic [2:0]    bf_sel,
  output logic          busy,
  output logic          frame_err
);
  state_e            state_q, state_d;
  logic [LAT:0]      vld_q, lst_q;
  logic [N_LOG2-1:0] in_cnt_q;
  logic              frame_err_q, accept, inflight, cnt0;
  // in_ready is gated by reset so nothing advances while reset is held
  always_comb begin
    s.in_ready = reset & s.out_ready & (state_q != FLUSH);
    accept     = s.in_valid & s.in_ready;
    adv        = (state_q == FLUSH) ? s.out_ready : accept;
    inflight   = |vld_q[LAT-1:0];
    cnt0       = in_cnt_q == '0;
    stage_en   = {adv & vld_q[OFS3], adv & vld_q[OFS2], accept};
    bf_sel     = {tw_addr3[0], tw_addr2[1], tw_addr1[2]};
    s.out_valid = vld_q[LAT];
    s.out_last  = lst_q[LAT];
    busy       = state_q != IDLE;
    frame_err  = frame_err_q;
    state_d    = state_q;
    // FLUSH ends on the advance that moves the final token onto the output
    state_d = (state_q == IDLE) ? (accept ? RUN : IDLE)
            : (state_q == RUN)  ? ((cnt0 & ~s.in_valid & s.out_ready & inflight) ? FLUSH
                                 : (cnt0 & ~inflight & ~accept) ? IDLE : RUN)
            : (adv & ~|vld_q[LAT-2:0]) ? IDLE : FLUSH;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      vld_q       <= '0;
      lst_q       <= '0;
      in_cnt_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (adv) begin
        vld_q <= {vld_q[LAT-1:0], accept};
        lst_q <= {lst_q[LAT-1:0], accept & s.in_last};
      end
      // in_last realigns the sample counter even when it arrives at the wrong position
      if (accept) in_cnt_q <= s.in_last ? '0 : in_cnt_q + 1'b1;
      frame_err_q <= accept & (s.in_last ^ (in_cnt_q == '1));
    end
  fft_stage_cnt u_cnt1 (.clk, .reset, .en_i(stage_en[0]), .clr_i(accept & s.in_last), .cnt_o(tw_addr1));
  fft_stage_cnt u_cnt2 (.clk, .reset, .en_i(stage_en[1]), .clr_i(adv & lst_q[OFS2]), .cnt_o(tw_addr2));
  fft_stage_cnt u_cnt3 (.clk, .reset, .en_i(stage_en[2]), .clr_i(adv & lst_q[OFS3]), .cnt_o(tw_addr3));
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: token-level model comparison plus directed frame scenarios
module tb_fft_seq_ctrl;
  localparam int LAT = 7, OFS2 = 4, OFS3 = 6;
  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2;
  typedef struct { int age; bit last; } tok_t;
  logic clk = 0, rst_n = 0;
  logic adv, busy, frame_err;
  logic [2:0] stage_en, tw_addr1, tw_addr2, tw_addr3, bf_sel;
  fft_seq_ctrl_if ifc ();
  fft_seq_ctrl dut (
    .clk(clk), .reset(rst_n), .s(ifc), .adv(adv), .stage_en(stage_en),
    .tw_addr1(tw_addr1), .tw_addr2(tw_addr2), .tw_addr3(tw_addr3),
    .bf_sel(bf_sel), .busy(busy), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int cnt_adv = 0, cnt_flush = 0, cnt_err = 0, rise_adv = 0;
  bit ov_prev = 0;
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: every accepted sample is a token aging by one per advance;
  // the result at the output is the token that has aged exactly LAT times.
  tok_t q[$], nq[$];
  int mode = M_IDLE, nmode, pos = 0, t1 = 0, t2 = 0, t3 = 0;
  bit err_m = 0, m_rdy, m_acc, m_adv, m_ov, m_ol, at2, at3, l2, l3, infl;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete(); mode = M_IDLE; pos = 0; t1 = 0; t2 = 0; t3 = 0; err_m = 0;
    end
    m_rdy = rst_n && ifc.out_ready && mode != M_FLUSH;
    m_acc = ifc.in_valid && m_rdy;
    m_adv = (mode == M_FLUSH) ? bit'(ifc.out_ready) : m_acc;
    m_ov = 0; m_ol = 0; at2 = 0; at3 = 0; l2 = 0; l3 = 0; infl = 0;
    foreach (q[i]) begin
      if (q[i].age == LAT) begin m_ov = 1; m_ol = q[i].last; end
      if (q[i].age == OFS2) begin at2 = 1; l2 = q[i].last; end
      if (q[i].age == OFS3) begin at3 = 1; l3 = q[i].last; end
      if (q[i].age < LAT) infl = 1;
    end
    chk("in_ready", ifc.in_ready, m_rdy);
    chk("adv", adv, m_adv);
    chk("stage_en", stage_en, {m_adv && at3, m_adv && at2, m_acc});
    chk("tw_addr1", tw_addr1, t1);
    chk("tw_addr2", tw_addr2, t2);
    chk("tw_addr3", tw_addr3, t3);
    chk("bf_sel", bf_sel, {t3[0], t2[1], t1[2]});
    chk("out_valid", ifc.out_valid, m_ov);
    chk("out_last", ifc.out_last, m_ol);
    chk("busy", busy, mode != M_IDLE);
    chk("frame_err", frame_err, err_m);
    if (ifc.out_valid && !ov_prev) rise_adv = cnt_adv;
    ov_prev = ifc.out_valid;
    cnt_adv += adv;
    cnt_flush += (busy && !ifc.in_ready && ifc.out_ready);
    cnt_err += frame_err;
    if (rst_n) begin
      nmode = mode;
      if (mode == M_IDLE) nmode = m_acc ? M_RUN : M_IDLE;
      else if (mode == M_RUN) begin
        if (pos == 0 && !ifc.in_valid && ifc.out_ready && infl) nmode = M_FLUSH;
        else if (pos == 0 && !infl && !m_acc) nmode = M_IDLE;
      end
      if (m_acc) t1 = ifc.in_last ? 0 : (t1 + 1) % 8;
      if (m_adv && at2) t2 = l2 ? 0 : (t2 + 1) % 8;
      if (m_adv && at3) t3 = l3 ? 0 : (t3 + 1) % 8;
      if (m_adv) begin
        nq.delete();
        foreach (q[i]) if (q[i].age < LAT) nq.push_back('{q[i].age + 1, q[i].last});
        if (m_acc) nq.push_back('{0, ifc.in_last});
        q = nq;
      end
      if (mode == M_FLUSH) begin
        infl = 0;
        foreach (q[i]) if (q[i].age < LAT) infl = 1;
        if (!infl) nmode = M_IDLE;
      end
      mode = nmode;
      err_m = m_acc && (ifc.in_last != (pos == 7));
      if (m_acc) pos = ifc.in_last ? 0 : (pos + 1) % 8;
    end
  end
  task automatic put(bit l);
    int w;
    @(posedge clk); #1;
    ifc.in_valid = 1; ifc.in_last = l; ifc.out_ready = 1;
    w = 0;
    @(negedge clk);
    while (!ifc.in_ready && w < 50) begin @(negedge clk); w++; end
    if (!ifc.in_ready) chk("put_timeout", 0, 1);
    #1;
  endtask
  task automatic idle(int n, bit r);
    repeat (n) begin @(posedge clk); #1; ifc.in_valid = 0; ifc.in_last = 0; ifc.out_ready = r; end
  endtask
  task automatic settle();
    @(negedge clk); #1;
  endtask
  task automatic frame8();
    for (int i = 0; i < 8; i++) put(i == 7);
  endtask
  int a0, f0, e0;
  initial begin
    ifc.in_valid = 0; ifc.in_last = 0; ifc.out_ready = 1;
    repeat (2) @(posedge clk);
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", ifc.out_valid, 0);
    @(posedge clk); #1 rst_n = 1;
    a0 = cnt_adv; f0 = cnt_flush;
    frame8();
    idle(20, 1); settle();
    chk("first_out_after_adv", rise_adv - a0, LAT + 1);
    chk("flush_cycles", cnt_flush - f0, 7);
    chk("idle_busy", busy, 0);
    f0 = cnt_flush;
    for (int i = 0; i < 16; i++) begin
      put(i % 8 == 7);
      if (i == 7) chk("tw1_before_wrap", tw_addr1, 7);
    end
    chk("b2b_no_flush", cnt_flush - f0, 0);
    idle(1, 1);
    chk("tw1_after_wrap", tw_addr1, 0);
    idle(20, 1);
    for (int i = 0; i < 3; i++) put(0);
    a0 = cnt_adv;
    idle(5, 1); settle();
    chk("gap_adv", cnt_adv - a0, 0);
    for (int i = 0; i < 5; i++) put(i == 4);
    idle(20, 1);
    e0 = cnt_err;
    for (int i = 0; i < 5; i++) put(i == 4);
    frame8();
    idle(20, 1); settle();
    chk("short_frame_err", cnt_err - e0, 1);
    frame8();
    idle(2, 1); settle();
    a0 = cnt_adv;
    idle(3, 0); settle();
    chk("stall_adv", cnt_adv - a0, 0);
    chk("stall_in_ready", ifc.in_ready, 0);
    idle(15, 1);
    for (int i = 0; i < 4; i++) put(0);
    @(posedge clk); #1 rst_n = 0; ifc.in_valid = 0;
    settle();
    chk("midrst_out_valid", ifc.out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tw1", tw_addr1, 0);
    @(posedge clk); #1 rst_n = 1;
    e0 = cnt_err;
    frame8();
    idle(20, 1); settle();
    chk("post_rst_err", cnt_err - e0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
